// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter driven by an external baud tick.
// Frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Accepting a byte moves the FSM to ARMED; the first tick after that starts
// the frame, so every bit (start included) lasts exactly one tick period.
module uart_tx #(
    parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS = 1    // 1 or 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_clk,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARMED = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] PAR   = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    logic [2:0]    state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [SW-1:0] stop_cnt;
    logic          par_bit;

    // Status decodes straight from the state register.
    always_comb begin
        tx_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // Frame sequencer; tx is only ever updated here, so it is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shreg    <= 8'h00;
            bit_cnt  <= 3'd0;
            stop_cnt <= '0;
            par_bit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A tick in the acceptance cycle is deliberately ignored.
                    if (tx_valid) begin
                        shreg   <= tx_data;
                        par_bit <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (tx_clk) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (tx_clk) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_cnt <= 3'd0;
                    end
                end
                DATA: begin
                    if (tx_clk) begin
                        if (bit_cnt == 3'd7) begin
                            stop_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                PAR: begin
                    if (tx_clk) begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_cnt <= '0;
                    end
                end
                STOP: begin
                    // Line already high; leave after the last stop period.
                    if (tx_clk) begin
                        if (stop_cnt == STOP_LAST) begin
                            state <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + SW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: four uart_tx instances (none/1, even/1, odd/1, none/2) share
// one stimulus stream; each is compared every cycle against a frame-queue
// reference model built from the bit-level frame description.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_clk = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_o [4];
    logic       rdy_o [4];
    logic       busy_o [4];

    localparam int PARS [4] = '{0, 2, 1, 0};
    localparam int SBS  [4] = '{1, 1, 1, 2};

    always #5 clk = ~clk;

    uart_tx #(.PARITY(0), .STOP_BITS(1)) u0 (.clk(clk), .rst(rst), .tx_clk(tx_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy_o[0]), .tx(tx_o[0]), .busy(busy_o[0]));
    uart_tx #(.PARITY(2), .STOP_BITS(1)) u1 (.clk(clk), .rst(rst), .tx_clk(tx_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy_o[1]), .tx(tx_o[1]), .busy(busy_o[1]));
    uart_tx #(.PARITY(1), .STOP_BITS(1)) u2 (.clk(clk), .rst(rst), .tx_clk(tx_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy_o[2]), .tx(tx_o[2]), .busy(busy_o[2]));
    uart_tx #(.PARITY(0), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .tx_clk(tx_clk), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(rdy_o[3]), .tx(tx_o[3]), .busy(busy_o[3]));

    int errors = 0;
    int checks = 0;
    int ph = 0;
    bit rnd_tick = 1'b0;
    bit cap_en = 1'b0;
    logic cap1 [$];
    logic cap2 [$];

    // Reference model: a frame is a list of line levels, one per tick.
    logic [11:0] mf [4];
    int          mn [4];
    int          mpos [4];
    logic        mbusy [4];
    logic        mtx [4];

    function automatic void build(input logic [7:0] d, input int par, input int sb,
                                  output logic [11:0] f, output int n);
        f = '1;
        n = 0;
        f[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin f[n] = d[i]; n++; end
        if (par != 0) begin
            f[n] = (par == 2) ? ^d : ~^d;
            n++;
        end
        for (int s = 0; s < sb; s++) begin f[n] = 1'b1; n++; end
    endfunction

    task automatic model_update();
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                mbusy[k] = 1'b0; mtx[k] = 1'b1; mpos[k] = 0;
            end else if (!mbusy[k]) begin
                if (tx_valid) begin
                    build(tx_data, PARS[k], SBS[k], mf[k], mn[k]);
                    mpos[k] = 0; mbusy[k] = 1'b1;
                end
            end else if (tx_clk) begin
                if (mpos[k] < mn[k]) begin
                    mtx[k] = mf[k][mpos[k]];
                    mpos[k]++;
                end else begin
                    mbusy[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input int k, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut=%0d observed=%b expected=%b t=%0t", tag, k, obs, exp, $time);
        end
    endtask

    // One clk cycle: model follows the edge, outputs checked 1 time unit later.
    task automatic cycle();
        bit tk;
        @(posedge clk);
        tk = tx_clk && !rst;
        model_update();
        #1;
        for (int k = 0; k < 4; k++) begin
            check("tx", k, tx_o[k], mtx[k]);
            check("busy", k, busy_o[k], mbusy[k]);
            check("tx_ready", k, rdy_o[k], !mbusy[k]);
        end
        if (cap_en && tk) begin
            cap1.push_back(tx_o[1]);
            cap2.push_back(tx_o[2]);
        end
    endtask

    // Free-running ticks every 4 clk (or random when rnd_tick is set).
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if (rnd_tick) tx_clk = ($urandom_range(0, 2) == 0);
            else          tx_clk = (ph % 4 == 3);
            ph++;
            cycle();
        end
    endtask

    task automatic send(input logic [7:0] d);
        tx_data = d; tx_valid = 1'b1;
        run(1);
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [10:0] e1;
        logic [10:0] e2;
        for (int k = 0; k < 4; k++) begin
            mbusy[k] = 1'b0; mtx[k] = 1'b1; mpos[k] = 0; mn[k] = 0; mf[k] = '1;
        end

        // Reset state
        rst = 1'b1; run(3);
        for (int k = 0; k < 4; k++) begin
            check("rst_tx", k, tx_o[k], 1'b1);
            check("rst_ready", k, rdy_o[k], 1'b1);
            check("rst_busy", k, busy_o[k], 1'b0);
        end
        rst = 1'b0; run(4);

        // 0x55, ticks every 4 clk
        ph = 0; send(8'h55); run(60);

        // 0x07 with a tick in the acceptance cycle; capture line at ticks
        tx_data = 8'h07; tx_valid = 1'b1; tx_clk = 1'b1;
        cycle();
        tx_valid = 1'b0; cap1.delete(); cap2.delete(); cap_en = 1'b1;
        ph = 0; run(60);
        cap_en = 1'b0;
        e1 = 11'b11000001110;
        e2 = 11'b10000001110;
        check("cap_len1", 1, cap1.size() >= 11, 1'b1);
        check("cap_len2", 2, cap2.size() >= 11, 1'b1);
        if (cap1.size() >= 11 && cap2.size() >= 11) begin
            for (int i = 0; i < 11; i++) begin
                check("even_frame_bit", 1, cap1[i], e1[i]);
                check("odd_frame_bit", 2, cap2[i], e2[i]);
            end
        end

        // 0xA3, two stop bits on dut 3
        ph = 0; send(8'hA3); run(60);

        // tx_valid held high with changing data: back-to-back frames
        tx_valid = 1'b1;
        for (int i = 0; i < 160; i++) begin
            tx_data = 8'($urandom);
            run(1);
        end
        tx_valid = 1'b0; run(60);

        // Reset during DATA bit 3 of dut 0, with tick and valid in same cycle
        ph = 0; send(8'hC6); run(20);
        rst = 1'b1; tx_clk = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        cycle();
        for (int k = 0; k < 4; k++) begin
            check("midrst_tx", k, tx_o[k], 1'b1);
            check("midrst_ready", k, rdy_o[k], 1'b1);
            check("midrst_busy", k, busy_o[k], 1'b0);
        end
        rst = 1'b0; tx_valid = 1'b0;
        run(5);
        ph = 0; send(8'h3C); run(60);

        // Tick held low mid-frame: line frozen
        ph = 0; send(8'h96); run(14);
        tx_clk = 1'b0;
        for (int i = 0; i < 30; i++) cycle();
        run(60);

        // Random bytes, random tick spacing, random valid
        rnd_tick = 1'b1;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 120; i++) begin
                tx_valid = ($urandom_range(0, 3) == 0);
                tx_data  = 8'($urandom);
                run(1);
            end
        end
        tx_valid = 1'b0; run(80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
